// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - key-code stream from the scanner FIFO to the calculator core
interface keypad_scanner_if #(
  parameter int CODE_W = 5
);
  logic [CODE_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_overflow;

  modport master (output o_data, output o_valid, output o_overflow, input i_ready);
  modport slave  (input o_data, input o_valid, input o_overflow, output i_ready);
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - matrix + direct-pin keypad scanner with debounce, lock-out, repeat and code FIFO
module keypad_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int NUM_DIRECT      = 6,
  parameter int CODE_W          = 5,
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_RATE     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ROWS-1:0]       o_row_drive,
  input  logic [COLS-1:0]       i_col_sense,
  input  logic [NUM_DIRECT-1:0] i_direct,
  keypad_scanner_if.master      kif
);
  localparam int NKEYS = ROWS*COLS + NUM_DIRECT;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DW    = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int HW    = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
  localparam logic [DW-1:0] DB_DONE     = DW'(DEBOUNCE_FRAMES);
  localparam logic [HW-1:0] REP_FIRST   = HW'(REPEAT_DELAY);
  localparam logic [HW-1:0] REP_NEXT    = HW'(REPEAT_DELAY + REPEAT_RATE);
  localparam logic [CW-1:0] FIFO_FULL   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD} state_t;

  logic [COLS-1:0]            r_col_s1, r_col_s2;
  logic [NUM_DIRECT-1:0]      r_dir_s1, r_dir_s2;
  logic [SW-1:0]              r_settle;
  logic [RW-1:0]              r_row_idx;
  logic [ROWS-1:0]            r_row_drive;
  logic [(ROWS-1)*COLS-1:0]   r_keys;
  state_t                     r_state;
  logic [CODE_W-1:0]          r_cand;
  logic [DW-1:0]              r_press_cnt, r_rel_cnt;
  logic [HW-1:0]              r_hold_cnt;
  logic [CODE_W-1:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]              r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic                       r_overflow;

  logic                       w_row_last, w_frame_end, w_any, w_hit, w_push, w_push_ok, w_pop;
  logic [NKEYS-1:0]           w_keys;
  logic [CODE_W-1:0]          w_cand, w_push_code;
  logic [DW-1:0]              w_press_nxt, w_rel_nxt;
  logic [HW-1:0]              w_hold_nxt;

  assign w_row_last  = (r_settle == SETTLE_LAST);
  assign w_frame_end = w_row_last && (r_row_idx == ROW_LAST);
  // Last row and direct pins are taken straight from the synchronisers on the frame-end cycle.
  assign w_keys      = {r_dir_s2, r_col_s2, r_keys};
  assign w_any       = |w_keys;
  assign w_hit       = w_keys[r_cand];
  assign w_press_nxt = r_press_cnt + 1'b1;
  assign w_rel_nxt   = r_rel_cnt + 1'b1;
  assign w_hold_nxt  = r_hold_cnt + 1'b1;
  assign o_row_drive = r_row_drive;

  always_comb begin
    w_cand = '0;
    for (int k = NKEYS - 1; k >= 0; k--) begin
      if (w_keys[k]) w_cand = CODE_W'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_s1    <= '0;
      r_col_s2    <= '0;
      r_dir_s1    <= '0;
      r_dir_s2    <= '0;
      r_settle    <= '0;
      r_row_idx   <= '0;
      r_row_drive <= ROWS'(1);
      r_keys      <= '0;
    end else begin
      r_col_s1 <= i_col_sense;
      r_col_s2 <= r_col_s1;
      r_dir_s1 <= i_direct;
      r_dir_s2 <= r_dir_s1;
      if (w_row_last) begin
        for (int r = 0; r < ROWS - 1; r++) begin
          if (r_row_idx == RW'(r)) r_keys[r*COLS +: COLS] <= r_col_s2;
        end
        r_settle    <= '0;
        r_row_idx   <= (r_row_idx == ROW_LAST) ? '0 : r_row_idx + 1'b1;
        r_row_drive <= {r_row_drive[ROWS-2:0], r_row_drive[ROWS-1]};
      end else begin
        r_settle <= r_settle + 1'b1;
      end
    end
  end

  always_comb begin
    w_push      = 1'b0;
    w_push_code = (r_state == S_SCAN) ? w_cand : r_cand;
    if (w_frame_end) begin
      case (r_state)
        S_SCAN:     w_push = w_any && (DB_DONE == DW'(1));
        S_DEBOUNCE: w_push = w_hit && (w_press_nxt == DB_DONE);
        S_HELD:     w_push = (REPEAT_EN != 0) && w_hit &&
                             ((w_hold_nxt == REP_FIRST) || (w_hold_nxt == REP_NEXT));
        default:    w_push = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_SCAN;
      r_cand      <= '0;
      r_press_cnt <= '0;
      r_rel_cnt   <= '0;
      r_hold_cnt  <= '0;
    end else if (w_frame_end) begin
      case (r_state)
        S_SCAN: if (w_any) begin
          r_cand      <= w_cand;
          r_press_cnt <= DW'(1);
          r_rel_cnt   <= '0;
          r_hold_cnt  <= '0;
          r_state     <= (DB_DONE == DW'(1)) ? S_HELD : S_DEBOUNCE;
        end
        S_DEBOUNCE: if (w_hit) begin
          r_press_cnt <= w_press_nxt;
          if (w_press_nxt == DB_DONE) begin
            r_state    <= S_HELD;
            r_rel_cnt  <= '0;
            r_hold_cnt <= '0;
          end
        end else begin
          r_state <= S_SCAN;
        end
        S_HELD: if (w_hit) begin
          r_rel_cnt <= '0;
          // Counter parks at REPEAT_DELAY after each repeat so it stays bounded while held.
          if (REPEAT_EN != 0) r_hold_cnt <= (w_hold_nxt == REP_NEXT) ? REP_FIRST : w_hold_nxt;
        end else begin
          r_rel_cnt <= w_rel_nxt;
          if (w_rel_nxt == DB_DONE) r_state <= S_SCAN;
        end
        default: r_state <= S_SCAN;
      endcase
    end
  end

  assign w_pop     = (r_count != '0) && kif.i_ready;
  assign w_push_ok = w_push && ((r_count != FIFO_FULL) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_push_code;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_overflow <= w_push && !w_push_ok;
    end
  end

  assign kif.o_data     = r_mem[r_rd_ptr];
  assign kif.o_valid    = (r_count != '0);
  assign kif.o_overflow = r_overflow;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner, default and auto-repeat instances
module tb_keypad_scanner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready = 1'b0;
  logic [15:0] keys_m = '0;
  logic [5:0]  keys_d = '0;
  logic [3:0]  row1, row2, col1, col2;
  int          cyc;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          d1[$], c1[$], ov1[$], d2[$], c2[$], ov2[$];

  keypad_scanner_if #(.CODE_W(5)) kif1 ();
  keypad_scanner_if #(.CODE_W(5)) kif2 ();
  assign kif1.i_ready = ready;
  assign kif2.i_ready = ready;

  keypad_scanner #(.REPEAT_EN(0)) dut1 (
    .clk(clk), .rst(rst), .o_row_drive(row1), .i_col_sense(col1), .i_direct(keys_d), .kif(kif1.master)
  );
  keypad_scanner #(.REPEAT_EN(1)) dut2 (
    .clk(clk), .rst(rst), .o_row_drive(row2), .i_col_sense(col2), .i_direct(keys_d), .kif(kif2.master)
  );

  always #5 clk = ~clk;

  // Passive key matrix: a closed key connects its row drive to its column.
  always_comb begin
    col1 = '0;
    col2 = '0;
    for (int r = 0; r < 4; r++) begin
      if (row1[r]) col1 = col1 | keys_m[r*4 +: 4];
      if (row2[r]) col2 = col2 | keys_m[r*4 +: 4];
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (kif1.o_valid && kif1.i_ready) begin d1.push_back(int'(kif1.o_data)); c1.push_back(cyc); end
      if (kif2.o_valid && kif2.i_ready) begin d2.push_back(int'(kif2.o_data)); c2.push_back(cyc); end
      if (kif1.o_overflow) ov1.push_back(cyc);
      if (kif2.o_overflow) ov2.push_back(cyc);
    end
  end

  task automatic press(input int code);
    if (code < 16) keys_m[code] = 1'b1;
    else           keys_d[code-16] = 1'b1;
  endtask

  task automatic release_all();
    keys_m = '0;
    keys_d = '0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_frames(input int n);
    run_cycles(16 * n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    release_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (row1 !== 4'b0001) begin n_fail++; $display("FAIL reset_row_drive: got %b expected 0001", row1); end
    n_cmp++; if (kif1.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", kif1.o_valid); end
    n_cmp++; if (kif1.o_data !== 5'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", kif1.o_data); end
    n_cmp++; if (kif1.o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", kif1.o_overflow); end
    n_cmp++; if (kif2.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_rep: got %b expected 0", kif2.o_valid); end
  endtask

  task automatic test_single_hold();
    int b, o;
    do_reset();
    ready = 1'b1;
    b = d1.size(); o = ov1.size();
    press(9);
    run_frames(10);
    release_all();
    run_frames(4);
    n_cmp++; if (d1.size() - b != 1) begin n_fail++; $display("FAIL hold_beats: got %0d expected 1", d1.size() - b); end
    n_cmp++; if (d1[b] != 9) begin n_fail++; $display("FAIL hold_code: got %0d expected 9", d1[b]); end
    n_cmp++; if (c1[b] != 48) begin n_fail++; $display("FAIL hold_valid_rise: got cycle %0d expected 48", c1[b]); end
    n_cmp++; if (ov1.size() != o) begin n_fail++; $display("FAIL hold_overflow: got %0d expected 0", ov1.size() - o); end
  endtask

  task automatic test_toggle_bounce();
    int b, o;
    do_reset();
    ready = 1'b1;
    b = d1.size(); o = ov1.size();
    for (int f = 0; f < 8; f++) begin
      if (f % 2 == 0) press(5); else release_all();
      run_frames(1);
    end
    release_all();
    run_frames(4);
    n_cmp++; if (d1.size() != b) begin n_fail++; $display("FAIL bounce_beats: got %0d expected 0", d1.size() - b); end
    n_cmp++; if (ov1.size() != o) begin n_fail++; $display("FAIL bounce_overflow: got %0d expected 0", ov1.size() - o); end
  endtask

  task automatic test_lockout();
    int b;
    do_reset();
    ready = 1'b1;
    b = d1.size();
    press(3); press(18);
    run_frames(5);
    keys_m[3] = 1'b0;
    run_frames(10);
    release_all();
    run_frames(4);
    n_cmp++; if (d1.size() - b != 2) begin n_fail++; $display("FAIL lockout_beats: got %0d expected 2", d1.size() - b); end
    n_cmp++; if (d1[b] != 3) begin n_fail++; $display("FAIL lockout_first: got %0d expected 3", d1[b]); end
    n_cmp++; if (c1[b] != 48) begin n_fail++; $display("FAIL lockout_first_cyc: got %0d expected 48", c1[b]); end
    n_cmp++; if (d1[b+1] != 18) begin n_fail++; $display("FAIL lockout_second: got %0d expected 18", d1[b+1]); end
    n_cmp++; if (c1[b+1] != 176) begin n_fail++; $display("FAIL lockout_second_cyc: got %0d expected 176", c1[b+1]); end
  endtask

  task automatic test_fifo_overflow();
    int b, o;
    do_reset();
    ready = 1'b0;
    b = d1.size(); o = ov1.size();
    for (int k = 1; k <= 5; k++) begin
      press(k);
      run_frames(3);
      release_all();
      run_frames(3);
    end
    n_cmp++; if (ov1.size() - o != 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d expected 1", ov1.size() - o); end
    n_cmp++; if (ov1[o] != 432) begin n_fail++; $display("FAIL ovf_cycle: got %0d expected 432", ov1[o]); end
    n_cmp++; if (d1.size() != b) begin n_fail++; $display("FAIL ovf_no_beats: got %0d expected 0", d1.size() - b); end
    n_cmp++; if (kif1.o_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b expected 1", kif1.o_valid); end
    n_cmp++; if (kif1.o_data !== 5'd1) begin n_fail++; $display("FAIL ovf_head: got %0d expected 1", kif1.o_data); end
    ready = 1'b1;
    run_cycles(8);
    n_cmp++; if (d1.size() - b != 4) begin n_fail++; $display("FAIL drain_beats: got %0d expected 4", d1.size() - b); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (d1[b+i] != i + 1) begin n_fail++; $display("FAIL drain_order[%0d]: got %0d expected %0d", i, d1[b+i], i + 1); end
    end
    n_cmp++; if (kif1.o_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", kif1.o_valid); end
  endtask

  task automatic test_auto_repeat();
    int b1, b2;
    int exp_cyc[5] = '{48, 560, 688, 816, 944};
    do_reset();
    ready = 1'b1;
    b1 = d1.size(); b2 = d2.size();
    press(5);
    run_frames(60);
    release_all();
    run_frames(6);
    n_cmp++; if (d2.size() - b2 != 5) begin n_fail++; $display("FAIL repeat_beats: got %0d expected 5", d2.size() - b2); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (d2[b2+i] != 5 || c2[b2+i] != exp_cyc[i]) begin
        n_fail++; $display("FAIL repeat_beat[%0d]: got code %0d cycle %0d expected code 5 cycle %0d", i, d2[b2+i], c2[b2+i], exp_cyc[i]);
      end
    end
    n_cmp++; if (d1.size() - b1 != 1) begin n_fail++; $display("FAIL norepeat_beats: got %0d expected 1", d1.size() - b1); end
  endtask

  task automatic test_reset_mid_debounce();
    int b;
    do_reset();
    ready = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      press(k);
      run_frames(3);
      release_all();
      run_frames(3);
    end
    press(7);
    run_frames(2);
    n_cmp++; if (kif1.o_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_queued: got %b expected 1", kif1.o_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (kif1.o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", kif1.o_valid); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ready = 1'b1;
    b = d1.size();
    run_frames(6);
    release_all();
    run_frames(4);
    n_cmp++; if (d1.size() - b != 1) begin n_fail++; $display("FAIL midrst_beats: got %0d expected 1", d1.size() - b); end
    n_cmp++; if (d1[b] != 7 || c1[b] != 48) begin
      n_fail++; $display("FAIL midrst_beat: got code %0d cycle %0d expected code 7 cycle 48", d1[b], c1[b]);
    end
  endtask

  initial begin
    test_reset();
    test_single_hold();
    test_toggle_bounce();
    test_lockout();
    test_fifo_overflow();
    test_auto_repeat();
    test_reset_mid_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
